// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the RISCV32I memory port (fetch vs load/store), with wait-cycle timeout.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [7:0] WAIT_MAX = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        m_req_q, m_req_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_ack_q, i_ack_d;
    logic        i_err_q, i_err_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        i_elig, d_elig, pick_d;

    // A request whose ack/err is showing this cycle is still held but must not be re-granted.
    assign i_elig = i_req & ~i_ack_q & ~i_err_q;
    assign d_elig = d_req & ~d_ack_q & ~d_err_q;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;

    always_comb begin
        pick_d   = d_elig & (~i_elig | ~last_d_q);
        last_d_d = last_d_q;
        if (state_q == IDLE && (i_elig || d_elig)) begin
            last_d_d = pick_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    always_comb begin
        pick_d = d_elig;
    end
`endif

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (pick_d) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (i_elig) begin
                    state_d   = BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_rdata_d = m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_ack_d   = 1'b1;
                    end
                end else if (wait_q == WAIT_MAX) begin
                    state_d = IDLE;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_err_d = 1'b1;
                    end else begin
                        i_err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign i_err   = i_err_q;
    assign i_rdata = i_rdata_q;
    assign d_ack   = d_ack_q;
    assign d_err   = d_err_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, store, contention, timeout and async reset, TIMEOUT=4.
module tb_mem_arbiter;

    localparam int unsigned TB_TIMEOUT = 4;
`ifdef MEM_ARB_RR_EN
    // Preceding store leaves D as last grant, so I wins the contention.
    localparam bit FIRST_D = 1'b0;
`else
    localparam bit FIRST_D = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ready;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic        i_ack, i_err, d_ack, d_err, m_req, m_we;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_d_rdata;

    mem_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic contend(input bit first_d);
        i_req = 1'b1; i_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0;
        step();
        check("ct_first_addr", m_addr, first_d ? 32'h400 : 32'h300);
        check("ct_first_mreq", {31'd0, m_req}, 32'd1);
        step();
        step();
        m_ready = 1'b1; m_rdata = 32'h1111_1111;
        step();
        m_ready = 1'b0;
        check("ct_first_ack", {31'd0, first_d ? d_ack : i_ack}, 32'd1);
        check("ct_other_noack", {31'd0, first_d ? i_ack : d_ack}, 32'd0);
        check("ct_mreq_gap", {31'd0, m_req}, 32'd0);
        step();
        if (first_d) d_req = 1'b0; else i_req = 1'b0;
        check("ct_second_mreq", {31'd0, m_req}, 32'd1);
        check("ct_second_addr", m_addr, first_d ? 32'h300 : 32'h400);
        step();
        step();
        m_ready = 1'b1; m_rdata = 32'h2222_2222;
        step();
        m_ready = 1'b0;
        check("ct_second_ack", {31'd0, first_d ? i_ack : d_ack}, 32'd1);
        check("ct_d_rdata", d_rdata, first_d ? 32'h1111_1111 : 32'h2222_2222);
        check("ct_i_rdata", i_rdata, first_d ? 32'h2222_2222 : 32'h1111_1111);
        exp_d_rdata = first_d ? 32'h1111_1111 : 32'h2222_2222;
        i_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_ready = 1'b0; m_rdata = '0;
        step();
        check("rst_mreq", {31'd0, m_req}, 32'd0);
        check("rst_acks", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
        check("rst_irdata", i_rdata, 32'd0);
        check("rst_drdata", d_rdata, 32'd0);
        check("rst_maddr", m_addr, 32'd0);
        rst = 1'b0;

        // m_ready while idle must be ignored
        m_ready = 1'b1; m_rdata = 32'h99;
        step();
        check("idle_ready_ack", {30'd0, i_ack, d_ack}, 32'd0);
        check("idle_ready_mreq", {31'd0, m_req}, 32'd0);
        m_ready = 1'b0; m_rdata = '0;
        step();

        // single fetch, minimum latency
        i_req = 1'b1; i_addr = 32'h100;
        step();
        check("f_mreq", {31'd0, m_req}, 32'd1);
        check("f_maddr", m_addr, 32'h100);
        check("f_mwe", {31'd0, m_we}, 32'd0);
        check("f_early_ack", {31'd0, i_ack}, 32'd0);
        m_ready = 1'b1; m_rdata = 32'hDEAD_BEEF;
        step();
        check("f_ack", {31'd0, i_ack}, 32'd1);
        check("f_rdata", i_rdata, 32'hDEAD_BEEF);
        check("f_dack", {31'd0, d_ack}, 32'd0);
        check("f_mreq_drop", {31'd0, m_req}, 32'd0);
        i_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
        step();
        check("f_ack_pulse", {31'd0, i_ack}, 32'd0);
        check("f_rdata_hold", i_rdata, 32'hDEAD_BEEF);

        // store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678;
        step();
        check("s_mreq", {31'd0, m_req}, 32'd1);
        check("s_mwe", {31'd0, m_we}, 32'd1);
        check("s_maddr", m_addr, 32'h2000);
        check("s_mwdata", m_wdata, 32'h1234_5678);
        step();
        check("s_mreq_hold", {31'd0, m_req}, 32'd1);
        check("s_early_ack", {31'd0, d_ack}, 32'd0);
        m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
        step();
        check("s_ack", {31'd0, d_ack}, 32'd1);
        check("s_rdata", d_rdata, 32'hCAFE_F00D);
        d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
        step();
        check("s_ack_pulse", {31'd0, d_ack}, 32'd0);

        contend(FIRST_D);

        // timeout on a load
        d_req = 1'b1; d_addr = 32'h500;
        step();
        for (int k = 0; k < int'(TB_TIMEOUT); k++) begin
            check("to_mreq", {31'd0, m_req}, 32'd1);
            check("to_no_err", {31'd0, d_err}, 32'd0);
            step();
        end
        check("to_mreq_drop", {31'd0, m_req}, 32'd0);
        check("to_err", {31'd0, d_err}, 32'd1);
        check("to_no_ack", {31'd0, d_ack}, 32'd0);
        check("to_rdata_hold", d_rdata, exp_d_rdata);
        d_req = 1'b0;
        step();
        check("to_err_pulse", {31'd0, d_err}, 32'd0);

        // fetch after timeout
        i_req = 1'b1; i_addr = 32'h600;
        step();
        check("af_maddr", m_addr, 32'h600);
        m_ready = 1'b1; m_rdata = 32'h3333_3333;
        step();
        check("af_ack", {31'd0, i_ack}, 32'd1);
        check("af_rdata", i_rdata, 32'h3333_3333);
        i_req = 1'b0; m_ready = 1'b0;
        step();

        // m_ready on the last allowed wait cycle completes normally
        i_req = 1'b1; i_addr = 32'h700;
        step();
        for (int k = 0; k < int'(TB_TIMEOUT) - 1; k++) step();
        check("edge_mreq", {31'd0, m_req}, 32'd1);
        m_ready = 1'b1; m_rdata = 32'h4444_4444;
        step();
        check("edge_ack", {31'd0, i_ack}, 32'd1);
        check("edge_no_err", {31'd0, i_err}, 32'd0);
        check("edge_rdata", i_rdata, 32'h4444_4444);
        i_req = 1'b0; m_ready = 1'b0;
        step();
        check("edge_no_late_err", {31'd0, i_err}, 32'd0);

        // async reset in second BUSY_I cycle
        i_req = 1'b1; i_addr = 32'h800;
        step();
        step();
        check("rr_mreq_before", {31'd0, m_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rr_mreq_async", {31'd0, m_req}, 32'd0);
        check("rr_flags", {30'd0, i_ack, i_err}, 32'd0);
        check("rr_irdata", i_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("rr_regrant", {31'd0, m_req}, 32'd1);
        check("rr_regrant_addr", m_addr, 32'h800);
        m_ready = 1'b1; m_rdata = 32'h5555_5555;
        step();
        check("rr_ack", {31'd0, i_ack}, 32'd1);
        check("rr_rdata", i_rdata, 32'h5555_5555);
        i_req = 1'b0; m_ready = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
